// File: rtl/seg_page_if.sv
// Bundle of source values, control inputs and display-multiplexer outputs
// for seg_page_scheduler.
interface seg_page_if;
    logic [15:0] pt_data;
    logic [15:0] key_data;
    logic [15:0] ct_data;
    logic        ct_valid;
    logic        hold;
    logic [3:0]  dig0;
    logic [3:0]  dig1;
    logic [3:0]  dig2;
    logic [3:0]  dig3;
    logic [1:0]  page;
    logic        blank;
    logic        ct_ack;

    modport master (
        output pt_data, key_data, ct_data, ct_valid, hold,
        input  dig0, dig1, dig2, dig3, page, blank, ct_ack
    );

    modport slave (
        input  pt_data, key_data, ct_data, ct_valid, hold,
        output dig0, dig1, dig2, dig3, page, blank, ct_ack
    );
endinterface

// File: rtl/seg_page_scheduler.sv
// Rotates PT/KEY/CT pages onto a 4-digit seven-segment display with blank gaps,
// ciphertext preemption and hold. Define SEG_LIVE_UPDATE_EN to track sources live.
module seg_page_scheduler #(
    parameter int unsigned DWELL_TICKS = 50000000,
    parameter int unsigned BLANK_TICKS = 1000000,
    parameter int unsigned CW          = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_page_if.slave  bus
);

    typedef enum logic {ST_BLANK, ST_SHOW} state_e;
    typedef enum logic [1:0] {
        PG_PT   = 2'b00,
        PG_KEY  = 2'b01,
        PG_CT   = 2'b10,
        PG_NONE = 2'b11
    } page_e;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    page_e         nxt_page, nxt_page_n;
    page_e         cur_page, cur_page_n;
    logic [15:0]   shown, shown_n;
    logic          ct_pend, ct_pend_n;
    logic          ct_seen, ct_seen_n;
    logic          ack_n;
    logic          ct_req;

    logic [15:0]   dig_q;
    page_e         page_q;
    logic          blank_q;
    logic          ack_q;

    function automatic logic [15:0] select_src(input page_e sel, input logic [15:0] pt,
                                                input logic [15:0] key, input logic [15:0] ct);
        case (sel)
            PG_PT:   return pt;
            PG_KEY:  return key;
            default: return ct;
        endcase
    endfunction

    // CT only joins the rotation once a ciphertext has ever been produced.
    function automatic page_e successor(input page_e cur, input logic seen);
        case (cur)
            PG_PT:   return PG_KEY;
            PG_KEY:  return seen ? PG_CT : PG_PT;
            default: return PG_PT;
        endcase
    endfunction

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        nxt_page_n = nxt_page;
        cur_page_n = cur_page;
        shown_n    = shown;
        ct_pend_n  = ct_pend | bus.ct_valid;
        ct_seen_n  = ct_seen | bus.ct_valid;
        ack_n      = 1'b0;
        ct_req     = bus.ct_valid | ct_pend;

        unique case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                    if (ct_pend) begin
                        cur_page_n = PG_CT;
                        ct_pend_n  = 1'b0;
                        ack_n      = 1'b1;
                    end else begin
                        cur_page_n = nxt_page;
                    end
                    shown_n = select_src(cur_page_n, bus.pt_data, bus.key_data, bus.ct_data);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_SHOW: begin
`ifdef SEG_LIVE_UPDATE_EN
                shown_n = select_src(cur_page, bus.pt_data, bus.key_data, bus.ct_data);
`endif
                if (ct_req && cur_page == PG_CT) begin
                    // Fresh ciphertext on the CT page: reload in place and restart the dwell.
                    shown_n   = bus.ct_data;
                    cnt_n     = '0;
                    ct_pend_n = 1'b0;
                    ack_n     = 1'b1;
                end else if (ct_req) begin
                    // Preemption beats both hold and the dwell count; ct_pend stays set.
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                end else if (!bus.hold) begin
                    if (cnt == DWELL_LAST) begin
                        state_n    = ST_BLANK;
                        cnt_n      = '0;
                        nxt_page_n = successor(cur_page, ct_seen);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            nxt_page <= PG_PT;
            cur_page <= PG_PT;
            shown    <= '0;
            ct_pend  <= 1'b0;
            ct_seen  <= 1'b0;
            dig_q    <= '0;
            page_q   <= PG_NONE;
            blank_q  <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            nxt_page <= nxt_page_n;
            cur_page <= cur_page_n;
            shown    <= shown_n;
            ct_pend  <= ct_pend_n;
            ct_seen  <= ct_seen_n;
            // Outputs are registered from the next-state view so they line up with state.
            blank_q  <= (state_n == ST_BLANK);
            page_q   <= (state_n == ST_BLANK) ? PG_NONE : cur_page_n;
            dig_q    <= (state_n == ST_BLANK) ? 16'h0000 : shown_n;
            ack_q    <= ack_n;
        end
    end

    assign bus.dig0   = dig_q[3:0];
    assign bus.dig1   = dig_q[7:4];
    assign bus.dig2   = dig_q[11:8];
    assign bus.dig3   = dig_q[15:12];
    assign bus.page   = page_q;
    assign bus.blank  = blank_q;
    assign bus.ct_ack = ack_q;

endmodule
